// File: rtl/ecc_err_monitor.sv
// ecc_err_monitor: ECC error counters, first-error capture, interrupt and scrub write-back FIFO
module ecc_err_monitor #(
  parameter int K          = 64,
  parameter int ADDR_W     = 27,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int SB_THRESH  = 8,
  parameter int SCRUB_EN   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [K-1:0]      data_i,
  input  logic              sb_err_i,
  input  logic              db_err_i,
  input  logic              clr_i,
  output logic [CNT_W-1:0]  sb_cnt_o,
  output logic [CNT_W-1:0]  db_cnt_o,
  output logic              err_valid_o,
  output logic              err_type_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic              ovf_o,
  output logic              irq_o,
  output logic              scrub_valid_o,
  input  logic              scrub_ready_i,
  output logic [ADDR_W-1:0] scrub_addr_o,
  output logic [K-1:0]      scrub_data_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [ADDR_W-1:0] mem_a [FIFO_DEPTH];
  logic [K-1:0]      mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       occ;
  logic              sb_evt, db_evt, base_v, base_t, load, full, pop, push, drop;
  logic [CNT_W-1:0]  sb_base, db_base, sb_nxt, db_nxt;
  assign scrub_valid_o = occ != '0;
  assign scrub_addr_o  = scrub_valid_o ? mem_a[rd_ptr] : '0;
  assign scrub_data_o  = scrub_valid_o ? mem_d[rd_ptr] : '0;
  // clear is applied before the current event so a same-cycle event is still recorded
  always_comb begin
    sb_evt  = valid_i & sb_err_i & ~db_err_i;
    db_evt  = valid_i & db_err_i;
    sb_base = clr_i ? '0 : sb_cnt_o;
    db_base = clr_i ? '0 : db_cnt_o;
    sb_nxt  = sb_base + CNT_W'(sb_evt && sb_base != '1);
    db_nxt  = db_base + CNT_W'(db_evt && db_base != '1);
    base_v  = ~clr_i & err_valid_o;
    base_t  = ~clr_i & err_type_o;
    load    = (sb_evt & ~base_v) | (db_evt & ~base_t);
    full    = occ == (PW+1)'(FIFO_DEPTH);
    pop     = scrub_valid_o & scrub_ready_i;
    push    = (SCRUB_EN != 0) & sb_evt & (~full | pop);
    drop    = (SCRUB_EN != 0) & sb_evt & full & ~pop;
  end
  // counters, capture, sticky overflow, interrupt and FIFO bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_cnt_o    <= '0;
      db_cnt_o    <= '0;
      err_valid_o <= 1'b0;
      err_type_o  <= 1'b0;
      err_addr_o  <= '0;
      ovf_o       <= 1'b0;
      irq_o       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
    end else begin
      sb_cnt_o    <= sb_nxt;
      db_cnt_o    <= db_nxt;
      err_valid_o <= base_v | load;
      err_type_o  <= load ? db_evt : base_t;
      err_addr_o  <= load ? addr_i : (clr_i ? '0 : err_addr_o);
      ovf_o       <= (~clr_i & ovf_o) | drop;
      irq_o       <= (db_nxt != '0) | (32'(sb_nxt) >= 32'(SB_THRESH));
      wr_ptr      <= wr_ptr + PW'(push);
      rd_ptr      <= rd_ptr + PW'(pop);
      occ         <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // FIFO storage needs no reset; empty entries are masked at the outputs
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_a[wr_ptr] <= addr_i;
      mem_d[wr_ptr] <= data_i;
    end
  end
endmodule

// File: tb/tb_ecc_err_monitor.sv
// tb_ecc_err_monitor: randomized and directed checks against a queue-based reference model
module tb_ecc_err_monitor;
  logic clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, sb_err_i = 1'b0, db_err_i = 1'b0, clr_i = 1'b0, scrub_ready_i = 1'b0;
  logic [26:0] addr_i = '0;
  logic [63:0] data_i = '0;
  logic [15:0] b_sb, b_db;
  logic [1:0]  s_sb, s_db;
  logic        b_ev, b_ty, b_ovf, b_irq, b_sv, s_ev, s_ty, s_ovf, s_irq, s_sv;
  logic [26:0] b_ea, b_sa, s_ea, s_sa;
  logic [63:0] b_sd, s_sd;
  int total = 0, bad = 0;
  int m_sb[2], m_db[2];
  bit m_irq[2];
  int m_max[2] = '{65535, 3};
  bit m_ev, m_ty, m_ovf;
  logic [26:0] m_ad;
  logic [26:0] qa[$];
  logic [63:0] qd[$];

  always #5 clk_i = ~clk_i;

  ecc_err_monitor u_big (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i),
    .sb_err_i(sb_err_i), .db_err_i(db_err_i), .clr_i(clr_i), .sb_cnt_o(b_sb), .db_cnt_o(b_db),
    .err_valid_o(b_ev), .err_type_o(b_ty), .err_addr_o(b_ea), .ovf_o(b_ovf), .irq_o(b_irq),
    .scrub_valid_o(b_sv), .scrub_ready_i(scrub_ready_i), .scrub_addr_o(b_sa), .scrub_data_o(b_sd));

  ecc_err_monitor #(.CNT_W(2)) u_small (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .addr_i(addr_i), .data_i(data_i),
    .sb_err_i(sb_err_i), .db_err_i(db_err_i), .clr_i(clr_i), .sb_cnt_o(s_sb), .db_cnt_o(s_db),
    .err_valid_o(s_ev), .err_type_o(s_ty), .err_addr_o(s_ea), .ovf_o(s_ovf), .irq_o(s_irq),
    .scrub_valid_o(s_sv), .scrub_ready_i(scrub_ready_i), .scrub_addr_o(s_sa), .scrub_data_o(s_sd));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit sbe, dbe, pop;
    if (rst_i) begin
      m_sb = '{0, 0}; m_db = '{0, 0}; m_irq = '{0, 0};
      m_ev = 0; m_ty = 0; m_ovf = 0; m_ad = '0;
      qa.delete(); qd.delete();
      return;
    end
    sbe = valid_i && sb_err_i && !db_err_i;
    dbe = valid_i && db_err_i;
    if (clr_i) begin
      m_sb = '{0, 0}; m_db = '{0, 0};
      m_ev = 0; m_ty = 0; m_ovf = 0; m_ad = '0;
    end
    for (int i = 0; i < 2; i++) begin
      if (sbe && m_sb[i] < m_max[i]) m_sb[i]++;
      if (dbe && m_db[i] < m_max[i]) m_db[i]++;
      m_irq[i] = (m_db[i] != 0) || (m_sb[i] >= 8);
    end
    if ((sbe || dbe) && (!m_ev || (dbe && !m_ty))) begin
      m_ev = 1; m_ty = dbe; m_ad = addr_i;
    end
    pop = qa.size() > 0 && scrub_ready_i;
    if (pop) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (sbe) begin
      if (qa.size() < 4) begin
        qa.push_back(addr_i);
        qd.push_back(data_i);
      end else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("b_sb", b_sb, m_sb[0]);
    check("b_db", b_db, m_db[0]);
    check("s_sb", s_sb, m_sb[1]);
    check("s_db", s_db, m_db[1]);
    check("b_irq", b_irq, m_irq[0]);
    check("s_irq", s_irq, m_irq[1]);
    check("b_ev", b_ev, m_ev);
    check("b_ty", b_ty, m_ty);
    check("b_ea", b_ea, m_ad);
    check("s_ea", s_ea, m_ad);
    check("b_ovf", b_ovf, m_ovf);
    check("s_ovf", s_ovf, m_ovf);
    check("b_sv", b_sv, qa.size() > 0);
    check("s_sv", s_sv, qa.size() > 0);
    if (qa.size() > 0) begin
      check("b_sa", b_sa, qa[0]);
      check("b_sd", b_sd, qd[0]);
      check("s_sa", s_sa, qa[0]);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [26:0] a, input logic [63:0] d, input bit s, input bit dbf, input bit c, input bit r);
    rst_i = 0; valid_i = v; addr_i = a; data_i = d; sb_err_i = s; db_err_i = dbf; clr_i = c; scrub_ready_i = r;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_i = 1;
    step();
    rst_i = 0;
  endtask

  initial begin
    do_reset();
    check("rst_sb", b_sb, 0);
    check("rst_sv", b_sv, 0);
    check("rst_sa", b_sa, 0);
    check("rst_sd", b_sd, 0);
    // single sb event
    drive(1, 27'h100, 64'hA5, 1, 0, 0, 0); step();
    check("tp1_sb", b_sb, 1);
    check("tp1_ev", b_ev, 1);
    check("tp1_ty", b_ty, 0);
    check("tp1_ea", b_ea, 27'h100);
    check("tp1_sv", b_sv, 1);
    check("tp1_sa", b_sa, 27'h100);
    check("tp1_sd", b_sd, 64'hA5);
    check("tp1_model", m_sb[0], 1);
    // sb then two db: first db overwrites, second does not
    do_reset();
    drive(1, 27'h10, 64'h1, 1, 0, 0, 1); step();
    check("tp2_irq0", b_irq, 0);
    drive(1, 27'h20, 64'h2, 0, 1, 0, 1); step();
    check("tp2_irq1", b_irq, 1);
    drive(1, 27'h30, 64'h3, 0, 1, 0, 1); step();
    check("tp2_ty", b_ty, 1);
    check("tp2_ea", b_ea, 27'h20);
    check("tp2_db", b_db, 2);
    check("tp2_sb", b_sb, 1);
    check("tp2_model", m_db[0], 2);
    // overflow with 5 pushes into depth 4
    do_reset();
    for (int k = 1; k <= 5; k++) begin drive(1, 27'(k), 64'(k * 3), 1, 0, 0, 0); step(); end
    check("tp3_ovf", b_ovf, 1);
    check("tp3_sb", b_sb, 5);
    for (int k = 1; k <= 4; k++) begin
      check("tp3_head", b_sa, 27'(k));
      drive(0, 0, 0, 0, 0, 0, 1); step();
    end
    check("tp3_empty", b_sv, 0);
    // push and pop while full
    do_reset();
    for (int k = 1; k <= 4; k++) begin drive(1, 27'(k), 64'(k), 1, 0, 0, 0); step(); end
    drive(1, 27'h40, 64'h40, 1, 0, 0, 1); step();
    check("tp4_ovf", b_ovf, 0);
    begin
      logic [26:0] exp_h [4] = '{27'h2, 27'h3, 27'h4, 27'h40};
      for (int k = 0; k < 4; k++) begin
        check("tp4_head", b_sa, exp_h[k]);
        drive(0, 0, 0, 0, 0, 0, 1); step();
      end
    end
    check("tp4_empty", b_sv, 0);
    // threshold and clear with simultaneous event
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(1, 27'(k), 64'(k), 1, 0, 0, 1); step();
      if (k == 7) check("tp5_irq7", b_irq, 0);
    end
    check("tp5_sb8", b_sb, 8);
    check("tp5_irq8", b_irq, 1);
    drive(1, 27'h77, 64'h77, 1, 0, 1, 1); step();
    check("tp5_sb", b_sb, 1);
    check("tp5_irq", b_irq, 0);
    check("tp5_ev", b_ev, 1);
    check("tp5_ea", b_ea, 27'h77);
    // saturation in the narrow instance and reset mid-stream
    do_reset();
    for (int k = 1; k <= 5; k++) begin drive(1, 27'(k), 64'(k), 0, 1, 0, 0); step(); end
    check("tp6_sdb", s_db, 3);
    check("tp6_bdb", b_db, 5);
    drive(1, 27'h5, 64'h5, 1, 0, 0, 0); step();
    drive(1, 27'h6, 64'h6, 1, 0, 0, 0); step();
    drive(1, 27'h7, 64'h7, 1, 0, 0, 1); rst_i = 1; step();
    check("tp6_sv", b_sv, 0);
    check("tp6_db", b_db, 0);
    check("tp6_sb", b_sb, 0);
    check("tp6_irq", b_irq, 0);
    check("tp6_ev", b_ev, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, 27'($urandom), {$urandom, $urandom}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      rst_i = $urandom_range(0, 299) == 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
